// File: rtl/ch_avg_seq.sv
// Sequencer ahead of the channel-estimate averager: buffers the first one or two
// DMRS symbols, then streams index-aligned 2/3-sample groups and counts results.
module ch_avg_seq #(
    parameter int INPUT_WIDTH = 16,
    parameter int DEPTH       = 64,
    parameter int LEN_W       = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_three_sym,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [INPUT_WIDTH-1:0]   est_i,
    input  logic [INPUT_WIDTH-1:0]   est_q,
    input  logic                     est_vld,
    output logic                     est_rdy,
    output logic [3*INPUT_WIDTH-1:0] avg_i_inputs,
    output logic [3*INPUT_WIDTH-1:0] avg_q_inputs,
    output logic [1:0]               avg_parallel_mode,
    output logic                     avg_in_vld,
    input  logic                     avg_out_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [INPUT_WIDTH-1:0] ZERO_W = '0;

    typedef enum logic [2:0] {IDLE, FILL0, FILL1, STREAM, DRAIN} state_t;

    state_t                   state;
    logic                     mode3;
    logic [LEN_W-1:0]         len;
    logic [LEN_W-1:0]         wr_idx;
    logic [LEN_W-1:0]         out_cnt;
    logic [2*INPUT_WIDTH-1:0] buf0 [DEPTH];
    logic [2*INPUT_WIDTH-1:0] buf1 [DEPTH];

    logic                     accept;
    logic                     last_idx;
    logic                     cfg_ok;
    logic [AW-1:0]            addr;
    logic [LEN_W-1:0]         out_cnt_nxt;
    logic [INPUT_WIDTH-1:0]   b0_i, b0_q, b1_i, b1_q;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        accept      = est_vld & est_rdy;
        last_idx    = (wr_idx == len - LEN_ONE);
        cfg_ok      = (cfg_len != '0) && (cfg_len <= DEPTH_L);
        addr        = wr_idx[AW-1:0];
        {b0_i, b0_q} = buf0[addr];
        {b1_i, b1_q} = buf1[addr];
        out_cnt_nxt = out_cnt;
        // Results are counted only while a job is streaming or draining, and never past len.
        if ((state == STREAM || state == DRAIN) && avg_out_vld && out_cnt != len)
            out_cnt_nxt = out_cnt + LEN_ONE;
    end

    // NOTE: the line buffers have no reset; every entry read in STREAM was
    // written by the fill of the same job, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (accept && state == FILL0) buf0[addr] <= {est_i, est_q};
        if (accept && state == FILL1) buf1[addr] <= {est_i, est_q};
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every read in this block sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            mode3             <= 1'b0;
            len               <= '0;
            wr_idx            <= '0;
            out_cnt           <= '0;
            est_rdy           <= 1'b0;
            avg_i_inputs      <= '0;
            avg_q_inputs      <= '0;
            avg_parallel_mode <= '0;
            avg_in_vld        <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            avg_in_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            mode3   <= cfg_three_sym;
                            len     <= cfg_len;
                            wr_idx  <= '0;
                            out_cnt <= '0;
                            est_rdy <= 1'b1;
                            busy    <= 1'b1;
                            state   <= FILL0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FILL0, FILL1: begin
                    if (accept) begin
                        if (last_idx) begin
                            wr_idx <= '0;
                            state  <= (state == FILL0 && mode3) ? FILL1 : STREAM;
                        end else begin
                            wr_idx <= wr_idx + LEN_ONE;
                        end
                    end
                end
                STREAM: begin
                    out_cnt <= out_cnt_nxt;
                    if (accept) begin
                        avg_in_vld        <= 1'b1;
                        avg_parallel_mode <= {1'b0, mode3};
                        avg_i_inputs      <= mode3 ? {b0_i, b1_i, est_i} : {b0_i, est_i, ZERO_W};
                        avg_q_inputs      <= mode3 ? {b0_q, b1_q, est_q} : {b0_q, est_q, ZERO_W};
                        if (last_idx) begin
                            wr_idx  <= '0;
                            est_rdy <= 1'b0;
                            state   <= DRAIN;
                        end else begin
                            wr_idx <= wr_idx + LEN_ONE;
                        end
                    end
                end
                DRAIN: begin
                    out_cnt <= out_cnt_nxt;
                    if (out_cnt_nxt == len) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ch_avg_seq.sv
// Bench for ch_avg_seq: random and directed jobs, a queue-based scoreboard of
// expected groups, and a variable-latency averager model driving avg_out_vld.
module tb_ch_avg_seq;

    localparam int W     = 16;
    localparam int DEPTH = 64;
    localparam int LEN_W = 7;

    logic             clk, rst, start, cfg_three_sym, est_vld, est_rdy;
    logic [LEN_W-1:0] cfg_len;
    logic [W-1:0]     est_i, est_q;
    logic [3*W-1:0]   avg_i_inputs, avg_q_inputs;
    logic [1:0]       avg_parallel_mode;
    logic             avg_in_vld, avg_out_vld, busy, done, cfg_err;

    ch_avg_seq #(.INPUT_WIDTH(W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_three_sym(cfg_three_sym),
        .cfg_len(cfg_len), .est_i(est_i), .est_q(est_q), .est_vld(est_vld),
        .est_rdy(est_rdy), .avg_i_inputs(avg_i_inputs), .avg_q_inputs(avg_q_inputs),
        .avg_parallel_mode(avg_parallel_mode), .avg_in_vld(avg_in_vld),
        .avg_out_vld(avg_out_vld), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3*W-1:0] i;
        logic [3*W-1:0] q;
        logic [1:0]     mode;
    } grp_t;

    grp_t exp_q[$];
    int   out_due[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_due = 0;
    int   job_len = 0, job_outs = 0, done_exp_cyc = -1, done_cnt = 0;
    bit   stray_req = 0;
    int   sym_i[3][DEPTH];
    int   sym_q[3][DEPTH];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitor: compares every issued group and schedules its averager result.
    always @(negedge clk) begin
        if (rst && avg_in_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_group: got i=%0h with nothing expected", avg_i_inputs);
            end else begin
                grp_t g;
                int   due;
                g = exp_q.pop_front();
                check("grp_i", avg_i_inputs, g.i);
                check("grp_q", avg_q_inputs, g.q);
                check("grp_mode", avg_parallel_mode, g.mode);
                due = cyc + int'($urandom_range(1, 3));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                out_due.push_back(due);
            end
        end
        if (rst && done) begin
            done_cnt++;
            check("done_timing", cyc, done_exp_cyc);
        end
    end

    // Averager model: one result per group, in order, latency 1..3 cycles.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        avg_out_vld = 1'b0;
        if (out_due.size() > 0 && out_due[0] == cyc) begin
            void'(out_due.pop_front());
            avg_out_vld = 1'b1;
            job_outs++;
            if (job_outs == job_len) done_exp_cyc = cyc + 1;
        end else if (stray_req && out_due.size() == 0) begin
            avg_out_vld = 1'b1;
            stray_req   = 0;
        end
    end

    task automatic fill_rand();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < DEPTH; k++) begin
                sym_i[s][k] = int'($urandom_range(0, 65535)) - 32768;
                sym_q[s][k] = int'($urandom_range(0, 65535)) - 32768;
            end
    endtask

    task automatic send(int i, int q);
        int n = 0;
        est_i   = W'(i);
        est_q   = W'(q);
        est_vld = 1'b1;
        @(negedge clk);
        while (!est_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!est_rdy) timeout_fail("est_rdy_wait");
        @(posedge clk);
        #1;
        est_vld = 1'b0;
    endtask

    task automatic push_expected(bit m3, int k);
        grp_t g;
        logic [W-1:0] a_i, a_q, b_i, b_q, c_i, c_q;
        a_i = W'(sym_i[0][k]); a_q = W'(sym_q[0][k]);
        b_i = W'(sym_i[1][k]); b_q = W'(sym_q[1][k]);
        c_i = W'(sym_i[2][k]); c_q = W'(sym_q[2][k]);
        if (m3) begin
            g.i = {a_i, b_i, c_i};
            g.q = {a_q, b_q, c_q};
        end else begin
            g.i = {a_i, b_i, W'(0)};
            g.q = {a_q, b_q, W'(0)};
        end
        g.mode = {1'b0, m3};
        exp_q.push_back(g);
    endtask

    task automatic begin_job(bit m3, int len);
        job_len       = len;
        job_outs      = 0;
        done_exp_cyc  = -1;
        cfg_three_sym = m3;
        cfg_len       = LEN_W'(len);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // gap < 0 picks a random 0..2 idle cycles after each sample.
    task automatic run_job(bit m3, int len, int gap, bit fill1_start);
        int nsym, dcount, n, g;
        nsym   = m3 ? 3 : 2;
        dcount = done_cnt;
        begin_job(m3, len);
        check("busy_after_start", busy, 1);
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < len; k++) begin
                if (fill1_start && s == 1 && k == 0) begin
                    start         = 1'b1;
                    cfg_three_sym = 1'b0;
                    cfg_len       = LEN_W'(1);
                end
                if (s == nsym - 1) push_expected(m3, k);
                send(sym_i[s][k], sym_q[s][k]);
                start = 1'b0;
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        check("rdy_drop_after_last", est_rdy, 0);
        est_vld = 1'b1;
        est_i   = W'($urandom);
        est_q   = W'($urandom);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        est_vld = 1'b0;
        n = 0;
        while (done_cnt == dcount && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == dcount) timeout_fail("done_wait");
        check("groups_left", exp_q.size(), 0);
        check("results_seen", job_outs, len);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_bad(int l);
        cfg_len = LEN_W'(l);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_rdy", est_rdy, 0);
        @(negedge clk);
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_still_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ctrl"}, {est_rdy, avg_in_vld, busy, done, cfg_err, avg_parallel_mode}, 0);
        check({tag, "_avg_i"}, avg_i_inputs, 0);
        check({tag, "_avg_q"}, avg_q_inputs, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_three_sym = 1'b0; cfg_len = '0;
        est_i = '0; est_q = '0; est_vld = 1'b0; avg_out_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Mode2, len=4, directed I values.
        fill_rand();
        for (int k = 0; k < 4; k++) begin
            sym_i[0][k] = 100 * (k + 1);
            sym_i[1][k] = 100 * (k + 3);
        end
        run_job(0, 4, 0, 0);

        // Mode3, len=3, identical symbols with Q negated.
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 3; k++) begin
                sym_i[s][k] = 3 * (k + 1);
                sym_q[s][k] = -3 * (k + 1);
            end
        run_job(1, 3, 0, 0);

        // Full depth, mode3, est_vld one cycle in three.
        fill_rand();
        run_job(1, DEPTH, 2, 0);

        cfg_bad(0);
        cfg_bad(DEPTH + 1);

        // Reset in STREAM after two of four groups.
        fill_rand();
        begin_job(0, 4);
        for (int k = 0; k < 4; k++) send(sym_i[0][k], sym_q[0][k]);
        for (int k = 0; k < 2; k++) begin
            push_expected(0, k);
            send(sym_i[1][k], sym_q[1][k]);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check_all_zero("mid_job_reset");
        exp_q.delete();
        out_due.delete();
        last_due     = cyc;
        job_outs     = 0;
        job_len      = 0;
        done_exp_cyc = -1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill_rand();
        run_job(0, 2, 0, 0);

        // Stray result pulse in IDLE, then start pulsed during FILL1.
        stray_req = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        fill_rand();
        run_job(1, 5, -1, 1);

        // Single-subcarrier jobs and a few random configurations.
        fill_rand();
        run_job(0, 1, 0, 0);
        fill_rand();
        run_job(1, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            fill_rand();
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(1, DEPTH)), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ch_avg_seq.md
Name: ch_avg_seq

Overview:
- Sequencer in front of the post-FFT channel-estimate averager.
- Captures per-subcarrier I/Q estimates of the first one or two DMRS-bearing symbols into an internal line buffer.
- While the last symbol streams in, issues aligned 2- or 3-sample groups (with mode select) to the averager, then counts averager outputs and signals completion.

Parameters:
- INPUT_WIDTH, 16, width of each I and Q estimate sample.
- DEPTH, 64, maximum subcarriers per symbol (line-buffer depth per stored symbol).
- LEN_W, 7, width of cfg_len; must hold DEPTH (ceil(log2(DEPTH+1))).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a job, sampled only in IDLE
- cfg_three_sym  input  1  1 = average 3 symbols, 0 = average 2; latched at start
- cfg_len  input  LEN_W  subcarriers per symbol, legal 1..DEPTH; latched at start
- est_i  input  INPUT_WIDTH  signed estimate, I
- est_q  input  INPUT_WIDTH  signed estimate, Q
- est_vld  input  1  estimate valid
- est_rdy  output  1  block accepts estimate this cycle
- avg_i_inputs  output  3*INPUT_WIDTH  concatenated I group to averager
- avg_q_inputs  output  3*INPUT_WIDTH  concatenated Q group to averager
- avg_parallel_mode  output  2  bit0 = 1 for 3-input mean, 0 for 2-input; bit1 = 0
- avg_in_vld  output  1  group valid to averager
- avg_out_vld  input  1  averager result valid, one per issued group
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse when the last averaged result has been observed
- cfg_err  output  1  one-cycle pulse when start carries an illegal cfg_len

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counters=0.
  - Outputs 0: est_rdy, avg_i_inputs, avg_q_inputs, avg_parallel_mode, avg_in_vld, busy, done, cfg_err.
  - Line-buffer contents are not reset.
  - Reset mid-job abandons the job; no done is issued.
- States: IDLE, FILL0, FILL1, STREAM, DRAIN.
- IDLE:
  - start with cfg_len in 1..DEPTH: latch mode3 and len, wr_idx=0, out_cnt=0, go to FILL0.
  - start with cfg_len=0 or >DEPTH: cfg_err=1 next cycle, stay IDLE.
  - start outside IDLE is ignored.
- est_rdy = 1 in FILL0, FILL1 and STREAM, 0 otherwise. A sample is accepted on est_vld & est_rdy; est_vld while est_rdy=0 is dropped.
- FILL0:
  - Accepted sample goes to buf0[wr_idx]; wr_idx++.
  - On the accept with wr_idx==len-1: wr_idx<=0; next state FILL1 if mode3, else STREAM.
- FILL1: same as FILL0, writes buf1; on the last accept go to STREAM.
- STREAM, each accepted sample at index k, outputs registered on the next cycle:
  - mode3: avg_*_inputs = {buf0[k], buf1[k], est}, MSB field first.
  - mode2: avg_*_inputs = {buf0[k], est, INPUT_WIDTH'b0}.
  - avg_parallel_mode = {1'b0, mode3}; avg_in_vld=1.
  - Cycles without an accept: avg_in_vld=0 and data holds its previous value.
  - On the accept with k==len-1: go to DRAIN.
- Latency: est accept at cycle t gives avg_in_vld at t+1. The averager returns avg_out_vld at t+2; its latency is registered and must be tolerated as any value >=1.
- Output counter:
  - out_cnt increments on avg_out_vld in STREAM or DRAIN; avg_out_vld in other states is ignored.
  - In DRAIN, when out_cnt reaches len (including the increment this cycle): done=1 for one cycle, go to IDLE.
  - avg_out_vld beyond len is ignored.
- Simultaneous events:
  - The last STREAM accept coinciding with an avg_out_vld is counted.
  - start in the same cycle as done (block in DRAIN) is ignored; it is honoured from IDLE only.
- Buffer read and write never address the same entry in one cycle: a fill writes one buffer, streaming reads both.
- len=1: FILL0 (and FILL1) last after a single accept; one group issued.

Test Plan:
- Mode2, len=4, symbol0 I=100,200,300,400 then symbol1 I=300,400,500,600 back-to-back -> four avg_in_vld pulses, avg_i_inputs fields {100,300,0}..{400,600,0}, parallel_mode=00, done one cycle after the 4th avg_out_vld.
- Mode3, len=3, I symbols {3,6,9},{3,6,9},{3,6,9}, Q negated -> groups {3,3,3},{6,6,6},{9,9,9}; parallel_mode=01; est_rdy drops after the 9th accept; done after the 3rd out_vld.
- Gapped est_vld (1 of 3 cycles) in mode3, len=DEPTH -> exactly DEPTH groups issued, index alignment preserved, no spurious avg_in_vld.
- start with cfg_len=0, then with cfg_len=DEPTH+1 -> cfg_err pulse each time, busy stays 0, est_rdy stays 0.
- rst asserted in STREAM after 2 of 4 groups -> all outputs 0 immediately; new start with len=2 completes normally with fresh data.
- start pulsed during FILL1, and avg_out_vld pulsed in IDLE -> both ignored; job result and done timing unchanged.
